hdmi_pll_tuner: RTL

- Supervisor and phase calibrator for the receive-side HDMI bit-clock PLL.
- Drives the PLL reset and 4-bit dynamic feedback delay, and watches PLL lock.
- Sweeps all 16 delay taps, scores each tap by the TMDS decoder's valid-symbol rate, then applies the best tap.
- Sits between the PLL wrapper and the TMDS channel decoders.

---
 rtl/hdmi_pll_tuner.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hdmi_pll_tuner.sv
// hdmi_pll_tuner: supervisor and feedback-delay calibrator for the HDMI RX
// bit-clock PLL. It resets the PLL, waits for lock, then sweeps all 16 delay
// taps. Each tap is scored by the TMDS valid-symbol rate, and the best tap is
// applied.
// Ports: clk_i, reset_i (sync, active-high), pll_locked_i, sym_valid_i
//        (both already in clk_i domain); pll_reset_o, delay_o[3:0],
//        calibrated_o, best_score_o (debug), sweeps_o (saturating at 255).
// Option: define HDMI_PLL_TUNER_RELOCK_EN so that a loss of lock in HOLD or
//         DONE triggers a full reset and re-sweep. Without it, the block stays
//         in DONE and only drops calibrated_o while lock is lost.
module hdmi_pll_tuner #(
   parameter int RESET_CYCLES  = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int SETTLE_CYCLES = 255,
   parameter int WINDOW        = 4096,
   parameter int MIN_SCORE     = 3584
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         pll_locked_i,
   input  logic                         sym_valid_i,
   output logic                         pll_reset_o,
   output logic [3:0]                   delay_o,
   output logic                         calibrated_o,
   output logic [$clog2(WINDOW+1)-1:0]  best_score_o,
   output logic [7:0]                   sweeps_o
);

   localparam int RW = $clog2(RESET_CYCLES + 1);
   localparam int LW = $clog2(LOCK_TIMEOUT + 1);
   localparam int TW = $clog2(SETTLE_CYCLES + 1);
   localparam int SW = $clog2(WINDOW + 1);

   localparam logic [SW-1:0] WIN_MAX = SW'(WINDOW);
   localparam logic [SW-1:0] MIN_S   = SW'(MIN_SCORE);

`ifdef HDMI_PLL_TUNER_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif

   typedef enum logic [2:0] {
      RST_PLL, WAIT_LOCK, SETTLE, MEASURE, EVAL, APPLY, HOLD, DONE
   } state_e;

   state_e         state_q, state_d;
   logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
   logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
   logic [TW-1:0]  settle_cnt_q, settle_cnt_d;
   logic [SW-1:0]  win_cnt_q, win_cnt_d;
   logic [SW-1:0]  score_q, score_d;
   logic [SW-1:0]  best_q, best_d;
   logic [3:0]     best_tap_q, best_tap_d;
   logic [3:0]     delay_q, delay_d;
   logic [SW-1:0]  best_score_q, best_score_d;
   logic [7:0]     sweeps_q, sweeps_d;
   logic           pll_reset_q, pll_reset_d;
   logic           calibrated_q, calibrated_d;

   logic rst_done, lock_to, settle_done, win_done;

   assign rst_done    = (rst_cnt_q == RW'(RESET_CYCLES - 1));
   assign lock_to     = (lock_cnt_q == LW'(LOCK_TIMEOUT - 1));
   assign settle_done = (settle_cnt_q == TW'(SETTLE_CYCLES - 1));
   assign win_done    = (win_cnt_q == SW'(WINDOW - 1));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= RST_PLL;
         rst_cnt_q    <= '0;
         lock_cnt_q   <= '0;
         settle_cnt_q <= '0;
         win_cnt_q    <= '0;
         score_q      <= '0;
         best_q       <= '0;
         best_tap_q   <= '0;
         delay_q      <= '0;
         best_score_q <= '0;
         sweeps_q     <= '0;
         pll_reset_q  <= 1'b1;
         calibrated_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         settle_cnt_q <= settle_cnt_d;
         win_cnt_q    <= win_cnt_d;
         score_q      <= score_d;
         best_q       <= best_d;
         best_tap_q   <= best_tap_d;
         delay_q      <= delay_d;
         best_score_q <= best_score_d;
         sweeps_q     <= sweeps_d;
         pll_reset_q  <= pll_reset_d;
         calibrated_q <= calibrated_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RST_PLL:
            if (rst_done) state_d = WAIT_LOCK;
         WAIT_LOCK:
            if (pll_locked_i) state_d = SETTLE;
            else if (lock_to) state_d = RST_PLL;
         SETTLE:
            if (!pll_locked_i) state_d = RST_PLL;
            else if (settle_done) state_d = MEASURE;
         MEASURE:
            if (!pll_locked_i) state_d = RST_PLL;
            else if (win_done) state_d = EVAL;
         EVAL:
            state_d = (delay_q == 4'd15) ? APPLY : SETTLE;
         APPLY:
            state_d = (best_q >= MIN_S) ? HOLD : RST_PLL;
         HOLD:
            if (RELOCK && !pll_locked_i) state_d = RST_PLL;
            else if (settle_done) state_d = DONE;
         DONE:
            if (RELOCK && !pll_locked_i) state_d = RST_PLL;
         default:
            state_d = RST_PLL;
      endcase
   end

   // Counters run only while their state persists and are cleared otherwise.
   always_comb begin
      rst_cnt_d    = '0;
      lock_cnt_d   = '0;
      settle_cnt_d = '0;
      win_cnt_d    = '0;
      score_d      = score_q;
      best_d       = best_q;
      best_tap_d   = best_tap_q;
      delay_d      = delay_q;
      best_score_d = best_score_q;
      sweeps_d     = sweeps_q;
      unique case (state_q)
         RST_PLL:
            if (state_d == RST_PLL) rst_cnt_d = rst_cnt_q + 1'b1;
         WAIT_LOCK:
            if (state_d == WAIT_LOCK) lock_cnt_d = lock_cnt_q + 1'b1;
         SETTLE: begin
            if (state_d == SETTLE) settle_cnt_d = settle_cnt_q + 1'b1;
            if (state_d == MEASURE) score_d = '0;
         end
         MEASURE: begin
            if (state_d == MEASURE) win_cnt_d = win_cnt_q + 1'b1;
            if (sym_valid_i && score_q != WIN_MAX) score_d = score_q + 1'b1;
         end
         EVAL: begin
            // Strict compare: on a tie the earlier (lower) tap is kept.
            if (score_q > best_q) begin
               best_d     = score_q;
               best_tap_d = delay_q;
            end
            if (delay_q != 4'd15) delay_d = delay_q + 4'd1;
         end
         APPLY: begin
            if (sweeps_q != 8'hFF) sweeps_d = sweeps_q + 8'd1;
            if (best_q >= MIN_S) begin
               delay_d      = best_tap_q;
               best_score_d = best_q;
            end
         end
         HOLD:
            if (state_d == HOLD) settle_cnt_d = settle_cnt_q + 1'b1;
         DONE: ;
         default: ;
      endcase
      // Any path back to RST_PLL abandons the sweep: tap 0, no best record.
      if (state_d == RST_PLL) begin
         delay_d    = '0;
         best_d     = '0;
         best_tap_d = '0;
      end
   end

   always_comb begin
      pll_reset_d  = (state_d == RST_PLL);
      calibrated_d = (state_d == DONE) && pll_locked_i;
   end

   assign pll_reset_o  = pll_reset_q;
   assign delay_o      = delay_q;
   assign calibrated_o = calibrated_q;
   assign best_score_o = best_score_q;
   assign sweeps_o     = sweeps_q;

endmodule
